// File: rtl/trng_pkg.sv
// Shared definitions for the metastability TRNG slice: calibration state
// encoding and the default bias-window geometry, which the online health-test
// block will reuse so both blocks judge bias in the same way.
package trng_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PI_RESET   = 3'd1,
      WAIT_LOCK  = 3'd2,
      BIAS_CHECK = 3'd3,
      RETRY      = 3'd4,
      RUN        = 3'd5,
      FAIL       = 3'd6
   } trng_cal_state_e;

   // Bias window of 2^TRNG_WIN_WIDTH samples, accepted when the ones count
   // lies within TRNG_BIAS_TOL of half the window (inclusive).
   localparam int TRNG_WIN_WIDTH = 8;
   localparam int TRNG_BIAS_TOL  = 16;

endpackage

// File: rtl/trng_cal_sequencer_if.sv
// Signal bundle between the calibration sequencer and its surroundings
// (phase controller, raw bit source, entropy consumer, host control).
//
// Signalling: enable is a level (0 forces the sequencer idle); start is a
// single-cycle request that is honoured only in IDLE, RUN or FAIL and ignored
// while busy. entropy_valid qualifies entropy_bit on every cycle it is high;
// there is no backpressure, so a consumer that is not ready simply drops bits.
// state is the registered FSM state, exported for observation only.
interface trng_cal_sequencer_if #(
   parameter int DL_CODE_WIDTH = 6,
   parameter int MAX_RETRY     = 3
);
   localparam int RC_WIDTH = $clog2(MAX_RETRY + 1);

   logic                         enable;
   logic                         start;
   logic                         pi_locked;
   logic                         pi_delay_update;
   logic [DL_CODE_WIDTH-1:0]     clk_code_in;
   logic [DL_CODE_WIDTH-1:0]     data_code_in;
   logic                         trng_bit;

   logic                         pi_rstn;
   logic                         busy;
   logic                         cal_done;
   logic                         cal_fail;
   logic                         entropy_valid;
   logic                         entropy_bit;
   logic [RC_WIDTH-1:0]          retry_count;
   logic [DL_CODE_WIDTH-1:0]     clk_code_snap;
   logic [DL_CODE_WIDTH-1:0]     data_code_snap;
   trng_pkg::trng_cal_state_e    state;

   // Sequencer side.
   modport slave (
      input  enable, start, pi_locked, pi_delay_update,
             clk_code_in, data_code_in, trng_bit,
      output pi_rstn, busy, cal_done, cal_fail, entropy_valid, entropy_bit,
             retry_count, clk_code_snap, data_code_snap, state
   );

   // Environment side (host, phase controller, bit source).
   modport master (
      output enable, start, pi_locked, pi_delay_update,
             clk_code_in, data_code_in, trng_bit,
      input  pi_rstn, busy, cal_done, cal_fail, entropy_valid, entropy_bit,
             retry_count, clk_code_snap, data_code_snap, state
   );

endinterface

// File: rtl/trng_bias_window.sv
// Ones-count bias window. Counts exactly 2^WIN_WIDTH samples while en is
// high and flags, on the final sample, whether the ones count is within
// BIAS_TOL of half the window. Counters are WIN_WIDTH+1 bits so that an
// all-ones window is representable and the deviation never wraps.
module trng_bias_window
   import trng_pkg::*;
#(
   parameter int WIN_WIDTH = TRNG_WIN_WIDTH,
   parameter int BIAS_TOL  = TRNG_BIAS_TOL
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   input  logic sample_bit,
   output logic window_done,
   output logic bias_ok
);
   localparam int CW = WIN_WIDTH + 1;
   localparam logic [CW-1:0] WIN_LAST = CW'((1 << WIN_WIDTH) - 1);
   localparam logic [CW-1:0] HALF     = CW'(1 << (WIN_WIDTH - 1));
   localparam logic [CW-1:0] TOL      = CW'(BIAS_TOL);

   logic [CW-1:0] sample_cnt;
   logic [CW-1:0] ones_cnt;
   logic [CW-1:0] ones_next;
   logic [CW-1:0] deviation;

   // Sample and ones counters; clr has priority so a fresh window always starts at zero.
   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         sample_cnt <= '0;
         ones_cnt   <= '0;
      end else if (en) begin
         sample_cnt <= sample_cnt + 1'b1;
         ones_cnt   <= ones_next;
      end
   end

   // The verdict includes the sample being taken this cycle, so the caller
   // can leave the window on the same edge that takes the last sample.
   assign ones_next   = ones_cnt + CW'(sample_bit);
   assign window_done = en && (sample_cnt == WIN_LAST);
   assign deviation   = (ones_next >= HALF) ? (ones_next - HALF) : (HALF - ones_next);
   assign bias_ok     = (deviation <= TOL);

endmodule

// File: rtl/trng_cal_sequencer.sv
// Calibration sequencer for the metastability TRNG slice. Resets the
// delay-line phase controller, waits for a stable lock (with timeout),
// qualifies the raw stream with a bias window, and only then releases
// entropy. Failed attempts are retried a bounded number of times; a delay
// update during RUN re-locks without resetting the phase controller.
module trng_cal_sequencer
   import trng_pkg::*;
#(
   parameter int DL_CODE_WIDTH = 6,
   parameter int PI_RST_CYCLES = 4,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int SETTLE_CYCLES = 16,
   parameter int WIN_WIDTH     = TRNG_WIN_WIDTH,
   parameter int BIAS_TOL      = TRNG_BIAS_TOL,
   parameter int MAX_RETRY     = 3
) (
   input logic                  clk,
   input logic                  rstn,
   trng_cal_sequencer_if.slave  bus
);
   localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
   localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);
   localparam int RST_W = $clog2(PI_RST_CYCLES + 1);
   localparam int RC_W  = $clog2(MAX_RETRY + 1);

   trng_cal_state_e          state;
   trng_cal_state_e          state_next;
   logic [RST_W-1:0]         rst_cnt;
   logic [RST_W-1:0]         rst_next;
   logic [TO_W-1:0]          to_cnt;
   logic [TO_W-1:0]          to_next;
   logic [ST_W-1:0]          settle_cnt;
   logic [ST_W-1:0]          settle_next;
   logic [RC_W-1:0]          retry_cnt;
   logic [RC_W-1:0]          retry_next;

   logic                     pi_rstn_q;
   logic                     busy_q;
   logic                     cal_done_q;
   logic                     cal_fail_q;
   logic                     entropy_valid_q;
   logic                     entropy_bit_q;
   logic [DL_CODE_WIDTH-1:0] clk_snap_q;
   logic [DL_CODE_WIDTH-1:0] data_snap_q;

   logic                     window_done;
   logic                     bias_ok;

   trng_bias_window #(
      .WIN_WIDTH (WIN_WIDTH),
      .BIAS_TOL  (BIAS_TOL)
   ) u_bias_window (
      .clk         (clk),
      .rstn        (rstn),
      .clr         (state != BIAS_CHECK),
      .en          (state == BIAS_CHECK),
      .sample_bit  (bus.trng_bit),
      .window_done (window_done),
      .bias_ok     (bias_ok)
   );

   // Next-state and counter update; every counter is zero outside its own state.
   always_comb begin
      state_next  = state;
      rst_next    = '0;
      to_next     = '0;
      settle_next = '0;
      retry_next  = retry_cnt;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = PI_RESET;
               retry_next = '0;
            end
         end
         PI_RESET: begin
            if (rst_cnt == RST_W'(PI_RST_CYCLES - 1)) state_next = WAIT_LOCK;
            else                                      rst_next   = rst_cnt + 1'b1;
         end
         WAIT_LOCK: begin
            to_next     = to_cnt + 1'b1;
            settle_next = bus.pi_locked ? (settle_cnt + 1'b1) : '0;
            // Lock is tested first so it wins a same-cycle timeout.
            if (settle_next == ST_W'(SETTLE_CYCLES))  state_next = BIAS_CHECK;
            else if (to_next == TO_W'(LOCK_TIMEOUT))  state_next = RETRY;
         end
         BIAS_CHECK: begin
            if (!bus.pi_locked)  state_next = RETRY;
            else if (window_done) state_next = bias_ok ? RUN : RETRY;
         end
         RETRY: begin
            if (retry_cnt == RC_W'(MAX_RETRY)) begin
               state_next = FAIL;
            end else begin
               state_next = PI_RESET;
               retry_next = retry_cnt + 1'b1;
            end
         end
         RUN: begin
            if (bus.start) begin
               state_next = PI_RESET;
               retry_next = '0;
            end else if (bus.pi_delay_update || !bus.pi_locked) begin
               state_next = WAIT_LOCK;
            end
         end
         FAIL: begin
            if (bus.start) begin
               state_next = PI_RESET;
               retry_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase

      if (!bus.enable) begin
         state_next = IDLE;
         retry_next = '0;
      end

      // Counters only carry over while the FSM stays in the owning state.
      if (state_next != PI_RESET || state != PI_RESET) rst_next = '0;
      if (state_next != WAIT_LOCK || state != WAIT_LOCK) begin
         to_next     = '0;
         settle_next = '0;
      end
   end

   // State, counters and all outputs registered together from the next state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state           <= IDLE;
         rst_cnt         <= '0;
         to_cnt          <= '0;
         settle_cnt      <= '0;
         retry_cnt       <= '0;
         pi_rstn_q       <= 1'b0;
         busy_q          <= 1'b0;
         cal_done_q      <= 1'b0;
         cal_fail_q      <= 1'b0;
         entropy_valid_q <= 1'b0;
         entropy_bit_q   <= 1'b0;
         clk_snap_q      <= '0;
         data_snap_q     <= '0;
      end else begin
         state           <= state_next;
         rst_cnt         <= rst_next;
         to_cnt          <= to_next;
         settle_cnt      <= settle_next;
         retry_cnt       <= retry_next;
         pi_rstn_q       <= !(state_next inside {IDLE, PI_RESET, FAIL});
         busy_q          <= (state_next inside {PI_RESET, WAIT_LOCK, BIAS_CHECK, RETRY});
         cal_done_q      <= (state_next == RUN);
         cal_fail_q      <= (state_next == FAIL);
         entropy_valid_q <= (state_next == RUN);
         entropy_bit_q   <= bus.trng_bit;
         if (state_next == RUN && state != RUN) begin
            clk_snap_q  <= bus.clk_code_in;
            data_snap_q <= bus.data_code_in;
         end
      end
   end

   assign bus.pi_rstn        = pi_rstn_q;
   assign bus.busy           = busy_q;
   assign bus.cal_done       = cal_done_q;
   assign bus.cal_fail       = cal_fail_q;
   assign bus.entropy_valid  = entropy_valid_q;
   assign bus.entropy_bit    = entropy_bit_q;
   assign bus.retry_count    = retry_cnt;
   assign bus.clk_code_snap  = clk_snap_q;
   assign bus.data_code_snap = data_snap_q;
   assign bus.state          = state;

endmodule
